// File: rtl/mem_traffic_checker.sv
// mem_traffic_checker
// Memory-controller bring-up traffic source and checker. Writes and reads an
// address-derived pattern on the controller master port. Keeps the addresses
// of outstanding reads in an in-order FIFO and checks every returned word
// against the pattern. Status counters saturate instead of wrapping.
module mem_traffic_checker #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 30,
    parameter int ID_W      = 2,
    parameter int MY_ID     = 1,
    parameter int MAX_OUTST = 8,
    parameter int STRIDE    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                mem_waitrequest,
    output logic [ID_W-1:0]     mem_id,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_writedatamask,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic [ID_W-1:0]     mem_readdataid,
    output logic [31:0]         errors,
    output logic [31:0]         reads_done,
    output logic [31:0]         writes_done,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                busy
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRIDE);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [ID_W-1:0]   OWN_ID    = ID_W'(MY_ID);
    localparam logic [31:0]       SAT_MAX   = 32'hFFFF_FFFF;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;
    localparam logic [1:0] MODE_READ  = 2'd2;
    localparam logic [1:0] MODE_MIXED = 2'd3;

    // The request currently presented on the master port.
    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_WRITE = 2'd1,
        REQ_READ  = 2'd2
    } req_e;

    // Data pattern for a word address: the address followed by its inverted
    // low nibble, truncated or zero-extended to the data width.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'({a, ~a[3:0]});
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == SAT_MAX) ? v : v + 32'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_e              req_q, req_d;
    req_e              next_kind;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [32:0]       lfsr_q;
    logic              lfsr_fb;

    logic [ADDR_W-1:0] fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0]  fifo_wr_ptr;
    logic [PTR_W-1:0]  fifo_rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;

    logic              ret_hit;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic              mismatch;
    logic              unexpected;
    logic              err_latched;
    logic              accept_write;
    logic              prefer_write;

    // ------------------------------------------------------------------
    // Static outputs and simple decodes
    // ------------------------------------------------------------------
    assign mem_id            = OWN_ID;
    assign mem_writedatamask = '1;
    assign mem_read          = (req_q == REQ_READ);
    assign mem_write         = (req_q == REQ_WRITE);
    assign busy              = mem_read | mem_write | ~fifo_empty;

    assign fifo_full    = (fifo_cnt == FULL_CNT);
    assign fifo_empty   = (fifo_cnt == '0);
    assign prefer_write = (lfsr_q[3:0] != 4'd0) | ~lfsr_q[4];
    assign lfsr_fb      = ~lfsr_q[32] ^ lfsr_q[19];
    assign accept_write = mem_write & ~mem_waitrequest;

    // Return checking is independent of issue: any return carrying our id
    // either retires the oldest outstanding read or is flagged unexpected.
    assign ret_hit    = (mem_readdataid == OWN_ID);
    assign pop        = ret_hit & ~fifo_empty;
    assign head_addr  = fifo_mem[fifo_rd_ptr];
    assign mismatch   = pop & (mem_readdata != pat(head_addr));
    assign unexpected = ret_hit & fifo_empty;

    // ------------------------------------------------------------------
    // Issue decision: what the port would load if the controller accepts
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        next_kind = REQ_IDLE;
        if (enable) begin
            case (mode)
                MODE_IDLE:  next_kind = REQ_IDLE;
                MODE_WRITE: next_kind = REQ_WRITE;
                MODE_READ:  next_kind = fifo_full ? REQ_IDLE : REQ_READ;
                MODE_MIXED: begin
                    // Reads only target addresses already written (rp behind wp).
                    if (prefer_write)
                        next_kind = REQ_WRITE;
                    else if ((rp_q != wp_q) && !fifo_full)
                        next_kind = REQ_READ;
                    else
                        next_kind = REQ_WRITE;
                end
                default:    next_kind = REQ_IDLE;
            endcase
        end
    end

    // Next request: hold everything while stalled, otherwise load the decision.
    always_comb begin
        req_d   = req_q;
        addr_d  = mem_address;
        wdata_d = mem_writedata;
        wp_d    = wp_q;
        rp_d    = rp_q;
        push    = 1'b0;
        if (!mem_waitrequest) begin
            req_d = next_kind;
            case (next_kind)
                REQ_WRITE: begin
                    addr_d  = wp_q;
                    wdata_d = pat(wp_q);
                    wp_d    = wp_q + ADDR_STEP;
                end
                REQ_READ: begin
                    addr_d = rp_q;
                    rp_d   = rp_q + ADDR_STEP;
                    push   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Request register: port outputs, write/read pointers and the LFSR.
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q         <= REQ_IDLE;
            mem_address   <= '0;
            mem_writedata <= '0;
            wp_q          <= '0;
            rp_q          <= '0;
            lfsr_q        <= '0;
        end else begin
            req_q         <= req_d;
            mem_address   <= addr_d;
            mem_writedata <= wdata_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            lfsr_q        <= {lfsr_q[31:0], lfsr_fb};
        end
    end

    // Expected-address FIFO storage.
    // NOTE: this small array is cleared on reset so the block's whole state
    // has a defined value; larger memories would normally be left unreset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[fifo_wr_ptr] <= rp_q;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Saturating status counters and first-mismatch capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            errors         <= '0;
            reads_done     <= '0;
            writes_done    <= '0;
            first_err_addr <= '0;
            err_latched    <= 1'b0;
        end else begin
            if (accept_write)
                writes_done <= sat_inc(writes_done);
            if (pop)
                reads_done <= sat_inc(reads_done);
            if (mismatch || unexpected)
                errors <= sat_inc(errors);
            if (mismatch && !err_latched) begin
                first_err_addr <= head_addr;
                err_latched    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_traffic_checker.sv
// tb_mem_traffic_checker
// Drives mem_traffic_checker with directed and randomized traffic, acts as a
// memory with variable in-order return latency, and compares every output on
// every cycle against a queue-based behavioural model of the block.
module tb_mem_traffic_checker;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 30;
    localparam int ID_W      = 2;
    localparam int MY_ID     = 1;
    localparam int MAX_OUTST = 8;
    localparam int STRIDE    = 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic                mem_waitrequest = 1'b0;
    logic [ID_W-1:0]     mem_id;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic [DATA_W/8-1:0] mem_writedatamask;
    logic [DATA_W-1:0]   mem_readdata = '0;
    logic [ID_W-1:0]     mem_readdataid = '0;
    logic [31:0]         errors;
    logic [31:0]         reads_done;
    logic [31:0]         writes_done;
    logic [ADDR_W-1:0]   first_err_addr;
    logic                busy;

    always #5 clock = ~clock;

    mem_traffic_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
        .MY_ID(MY_ID), .MAX_OUTST(MAX_OUTST), .STRIDE(STRIDE)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .mode              (mode),
        .mem_waitrequest   (mem_waitrequest),
        .mem_id            (mem_id),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid),
        .errors            (errors),
        .reads_done        (reads_done),
        .writes_done       (writes_done),
        .first_err_addr    (first_err_addr),
        .busy              (busy)
    );

    // ------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit                m_read, m_write, m_first_seen;
    logic [ADDR_W-1:0] m_addr, m_wp, m_rp, m_first;
    logic [DATA_W-1:0] m_wdata;
    longint unsigned   m_err, m_rd, m_wr;
    logic [32:0]       m_lfsr;
    logic [ADDR_W-1:0] m_q[$];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [63:0] v;
        v = {34'd0, a};
        v = (v << 4) | {60'd0, ~a[3:0]};
        return v[DATA_W-1:0];
    endfunction

    function automatic longint unsigned sat(input longint unsigned v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_reset();
        m_read = 0; m_write = 0; m_first_seen = 0;
        m_addr = '0; m_wp = '0; m_rp = '0; m_first = '0; m_wdata = '0;
        m_err = 0; m_rd = 0; m_wr = 0; m_lfsr = '0;
        m_q.delete();
    endtask

    // One clock edge of the model, given the inputs present at that edge.
    task automatic model_step(input bit en, input logic [1:0] md, input bit wr,
                              input logic [ID_W-1:0] rid, input logic [DATA_W-1:0] rdata);
        int               occ;
        int               kind;   // 0 idle, 1 write, 2 read
        bit               pref;
        logic [ADDR_W-1:0] a;
        occ = m_q.size();
        if (m_write && !wr) m_wr = sat(m_wr);
        if (rid == ID_W'(MY_ID)) begin
            if (m_q.size() != 0) begin
                a = m_q.pop_front();
                m_rd = sat(m_rd);
                if (rdata != pat(a)) begin
                    m_err = sat(m_err);
                    if (!m_first_seen) begin m_first = a; m_first_seen = 1; end
                end
            end else begin
                m_err = sat(m_err);
            end
        end
        if (!wr) begin
            pref = ((m_lfsr & 33'hF) != 0) || (((m_lfsr >> 4) & 33'h1) == 0);
            if (!en || md == 2'd0)      kind = 0;
            else if (md == 2'd1)        kind = 1;
            else if (md == 2'd2)        kind = (occ < MAX_OUTST) ? 2 : 0;
            else if (pref)              kind = 1;
            else if (m_rp != m_wp && occ < MAX_OUTST) kind = 2;
            else                        kind = 1;
            m_write = (kind == 1);
            m_read  = (kind == 2);
            if (kind == 1) begin
                m_addr = m_wp; m_wdata = pat(m_wp); m_wp = m_wp + ADDR_W'(STRIDE);
            end else if (kind == 2) begin
                m_addr = m_rp; m_q.push_back(m_rp); m_rp = m_rp + ADDR_W'(STRIDE);
            end
        end
        m_lfsr = (m_lfsr << 1) | {32'd0, (~m_lfsr[32]) ^ m_lfsr[19]};
    endtask

    // ------------------------------------------------------------------
    // Stimulus controls and memory responder
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned       due;
        logic [ADDR_W-1:0] addr;
    } ret_t;

    ret_t              ret_q[$];
    int unsigned       cyc = 0;
    int unsigned       last_due = 0;
    logic [DATA_W-1:0] mem_img [logic [ADDR_W-1:0]];
    bit                written [logic [ADDR_W-1:0]];

    bit                c_en = 0;
    logic [1:0]        c_mode = 2'd0;
    bit                c_wr = 0;
    int                c_wr_pct = 0;
    int                c_lat_lo = 1, c_lat_hi = 1;
    bit                c_corrupt_on = 0;
    logic [ADDR_W-1:0] c_corrupt = '0;
    int                c_inj = -1;
    bit                chk_outst = 0, chk_raw = 0;
    int                max_outst = 0;
    int                reads_acc = 0;

    task automatic compare_all();
        check("mem_read", mem_read, m_read);
        check("mem_write", mem_write, m_write);
        if (m_read || m_write) check("mem_address", mem_address, m_addr);
        if (m_write) check("mem_writedata", mem_writedata, m_wdata);
        check("mem_id", mem_id, MY_ID);
        check("mem_writedatamask", mem_writedatamask, 4'hF);
        check("errors", errors, m_err[31:0]);
        check("reads_done", reads_done, m_rd[31:0]);
        check("writes_done", writes_done, m_wr[31:0]);
        check("first_err_addr", first_err_addr, m_first);
        check("busy", busy, (m_read || m_write || m_q.size() != 0));
    endtask

    // Called just after a falling edge: check, drive the next inputs, advance.
    task automatic tick();
        bit                wr;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        ret_t              r;
        int                occ;
        compare_all();
        if (chk_outst) begin
            occ = ret_q.size() + (mem_read ? 1 : 0);
            check("outstanding_bound", occ <= MAX_OUTST, 1);
            if (occ > max_outst) max_outst = occ;
        end
        if (chk_raw && mem_read) check("read_after_write", written.exists(mem_address), 1);

        wr = (c_wr_pct > 0) ? ($urandom_range(99) < c_wr_pct) : c_wr;

        rid   = '0;
        rdata = $urandom;
        if (c_inj >= 0) begin
            rid = ID_W'(c_inj);
        end else if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            r     = ret_q.pop_front();
            rid   = ID_W'(MY_ID);
            rdata = mem_img.exists(r.addr) ? mem_img[r.addr] : pat(r.addr);
            if (c_corrupt_on && r.addr == c_corrupt) rdata[0] = ~rdata[0];
        end

        if (mem_write && !wr) begin
            mem_img[mem_address] = mem_writedata;
            written[mem_address] = 1;
        end
        if (mem_read && !wr) begin
            r.due  = cyc + $urandom_range(c_lat_hi, c_lat_lo);
            if (r.due <= last_due) r.due = last_due + 1;
            r.addr = mem_address;
            last_due = r.due;
            ret_q.push_back(r);
            reads_acc++;
        end

        enable          = c_en;
        mode            = c_mode;
        mem_waitrequest = wr;
        mem_readdataid  = rid;
        mem_readdata    = rdata;
        model_step(c_en, c_mode, wr, rid, rdata);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clock);
        model_reset();
        written.delete();
        reads_acc = 0;
        reset = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read"}, mem_read, 0);
        check({tag, "_write"}, mem_write, 0);
        check({tag, "_address"}, mem_address, 0);
        check({tag, "_writedata"}, mem_writedata, 0);
        check({tag, "_errors"}, errors, 0);
        check({tag, "_reads_done"}, reads_done, 0);
        check({tag, "_writes_done"}, writes_done, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_id"}, mem_id, MY_ID);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DATA_W-1:0] t1_data [4];
        logic [ADDR_W-1:0] hold_addr;
        logic [DATA_W-1:0] hold_data;
        int                stale;

        t1_data[0] = 32'h0000_000F;
        t1_data[1] = 32'h0000_001E;
        t1_data[2] = 32'h0000_002D;
        t1_data[3] = 32'h0000_003C;

        model_reset();
        repeat (2) @(negedge clock);
        check_reset_values("por");
        reset = 0;

        // 1. Write-only, no stalls: four writes with known pattern data.
        c_en = 1; c_mode = 2'd1; c_wr = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_addr", mem_address, k);
            check("t1_data", mem_writedata, t1_data[k]);
        end
        c_en = 0;
        tick();
        check("t1_writes_done", writes_done, 4);
        check("t1_idle", mem_write, 0);

        // 2. Stall mid-stream: request holds, nothing skipped afterwards.
        c_en = 1;
        tick();
        tick();
        hold_addr = mem_address;
        hold_data = mem_writedata;
        check("t2_hold_addr", hold_addr, 5);
        c_wr = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_addr_stable", mem_address, hold_addr);
            check("t2_data_stable", mem_writedata, hold_data);
            check("t2_writes_stalled", writes_done, 5);
        end
        c_wr = 0;
        tick();
        check("t2_next_addr", mem_address, 6);
        check("t2_writes_after", writes_done, 6);

        // Fill memory further under random stalls.
        c_wr_pct = 25;
        repeat (100) tick();
        c_wr_pct = 0; c_wr = 0; c_en = 0;
        repeat (2) tick();

        // 3. Read-only, 20-cycle latency: outstanding bounded at MAX_OUTST.
        c_lat_lo = 20; c_lat_hi = 20;
        chk_outst = 1; max_outst = 0; reads_acc = 0;
        c_en = 1; c_mode = 2'd2;
        repeat (60) tick();
        c_en = 0;
        repeat (40) tick();
        chk_outst = 0;
        check("t3_max_outstanding", max_outst, MAX_OUTST);
        check("t3_errors", errors, 0);
        check("t3_reads_done", reads_done, reads_acc);
        check("t3_busy_drained", busy, 0);

        // 4. Corrupted return for address 5.
        do_reset();
        c_corrupt_on = 1; c_corrupt = 5;
        c_lat_lo = 3; c_lat_hi = 3;
        c_en = 1; c_mode = 2'd2;
        repeat (20) tick();
        c_en = 0;
        repeat (20) tick();
        check("t4_errors", errors, 1);
        check("t4_first_err_addr", first_err_addr, 5);
        check("t4_reads_done", reads_done, reads_acc);
        c_corrupt_on = 0;

        // 5. Unexpected return, then a return tagged with a foreign id.
        do_reset();
        repeat (2) tick();
        c_inj = MY_ID;
        tick();
        c_inj = -1;
        tick();
        check("t5_errors", errors, 1);
        check("t5_reads_done", reads_done, 0);
        c_inj = 2;
        tick();
        c_inj = -1;
        tick();
        check("t5_foreign_id_ignored", errors, 1);

        // 6. Mixed mode, random stalls and latency, async reset mid-burst.
        do_reset();
        chk_raw = 1;
        c_lat_lo = 1; c_lat_hi = 12;
        c_wr_pct = 30;
        c_en = 1; c_mode = 2'd3;
        repeat (3000) tick();
        check("t6_errors_before_reset", errors, 0);
        check("t6_reads_done", reads_done, reads_acc - ret_q.size());
        chk_raw = 0;
        #2 reset = 1;
        #1;
        check_reset_values("async");
        stale = ret_q.size();
        @(negedge clock);
        @(negedge clock);
        model_reset();
        written.delete();
        reset = 0;
        c_en = 0; c_wr_pct = 0; c_wr = 0;
        repeat (40) tick();
        check("t6_stale_returns", errors, stale);
        check("t6_reads_after_reset", reads_done, 0);
        check("t6_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
